// File: rtl/diff_pkg.sv
// diff_pkg: shared limits and helpers for the diff_nth_mc
// multi-channel backward-difference filter.
package diff_pkg;

    localparam int MAX_ORDER    = 6;
    localparam int MAX_CHANNELS = 16;
    localparam int MAX_W        = 64;
    localparam int CNT_W        = 3;

    function automatic int tag_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Clamp and wrap overflow on exactly the same condition: v outside out_w range
    function automatic logic sat_ovf(
        input logic signed [MAX_W-1:0] v,
        input int                      out_w
    );
        logic signed [MAX_W-1:0] hi;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        return (v > hi) || (v < ~hi);
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_val(
        input logic signed [MAX_W-1:0] v,
        input int                      out_w,
        input logic                    sat
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        int                      sh;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = ~hi;
        sh = MAX_W - out_w;
        if (!sat)
            return (v <<< sh) >>> sh;
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/diff_stage.sv
// diff_stage: one registered first-order difference with
// per-channel history; data, tag and settled bit travel together.
module diff_stage
    import diff_pkg::*;
#(
    parameter int  IN_W     = 16,
    parameter int  CHANNELS = 1,
    parameter bit  FIRST    = 1'b0,
    localparam int TAG_W    = tag_w(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic signed [IN_W-1:0] in_d,
    input  logic                   in_valid,
    input  logic [TAG_W-1:0]       in_chan,
    input  logic                   in_settled,
    input  logic                   clr,
    input  logic [TAG_W-1:0]       clr_chan,
    output logic signed [IN_W:0]   out_d,
    output logic                   out_valid,
    output logic [TAG_W-1:0]       out_chan,
    output logic                   out_settled
);

    localparam int DEPTH = 1 << TAG_W;

    logic signed [IN_W-1:0] hist [DEPTH];
    logic signed [IN_W-1:0] h_rd;
    logic                   clr_hit;

    assign clr_hit = clr && in_valid && (clr_chan == in_chan);

    // At stage 1 a coincident clear makes this the first post-clear sample;
    // deeper stages hold older samples, so the clear wins there.
    always_comb begin
        h_rd = hist[in_chan];
        if (FIRST && clr_hit)
            h_rd = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_d       <= '0;
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_settled <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                hist[i] <= '0;
        end else if (clk_enable) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_d       <= (IN_W+1)'(in_d) - (IN_W+1)'(h_rd);
                out_chan    <= in_chan;
                out_settled <= in_settled;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (in_valid && in_chan == TAG_W'(i) && (FIRST || !clr_hit))
                    hist[i] <= in_d;
                else if (clr && clr_chan == TAG_W'(i))
                    hist[i] <= '0;
            end
        end
    end

endmodule

// File: rtl/diff_nth_mc.sv
// diff_nth_mc: ORDER-th backward difference over CHANNELS interleaved
// streams, with settled tracking and saturating/wrapping output.
module diff_nth_mc
    import diff_pkg::*;
#(
    parameter int  ORDER    = 3,
    parameter int  CHANNELS = 1,
    parameter int  WIDTH    = 51,
    parameter int  OUT_W    = WIDTH + ORDER,
    parameter int  SAT      = 1,
    localparam int TAG_W    = tag_w(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic signed [WIDTH-1:0] xin,
    input  logic                    xin_valid,
    input  logic [TAG_W-1:0]        xin_chan,
    input  logic                    clr,
    input  logic [TAG_W-1:0]        clr_chan,
    output logic signed [OUT_W-1:0] yout,
    output logic                    yout_valid,
    output logic [TAG_W-1:0]        yout_chan,
    output logic                    yout_settled,
    output logic                    yout_ovf
);

    localparam int FULL_W = WIDTH + ORDER;
    localparam int DEPTH  = 1 << TAG_W;

    logic [CNT_W-1:0]         cnt [DEPTH];
    logic [CNT_W-1:0]         cnt_rd;
    logic                     accept;
    logic                     clr_hit;
    logic                     settle0;
    logic signed [FULL_W-1:0] fin;
    logic                     fin_valid;
    logic [TAG_W-1:0]         fin_chan;
    logic                     fin_settled;

    assign accept  = xin_valid && (int'(xin_chan) < CHANNELS);
    assign clr_hit = clr && (clr_chan == xin_chan);
    assign cnt_rd  = clr_hit ? '0 : cnt[xin_chan];
    assign settle0 = (cnt_rd == CNT_W'(ORDER));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= '0;
        end else if (clk_enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && xin_chan == TAG_W'(i))
                    cnt[i] <= settle0 ? cnt_rd : cnt_rd + 1'b1;
                else if (clr && clr_chan == TAG_W'(i))
                    cnt[i] <= '0;
            end
        end
    end

    for (genvar k = 1; k <= ORDER; k++) begin : g_stg
        logic signed [WIDTH+k-2:0] a;
        logic signed [WIDTH+k-1:0] q;
        logic                      vi;
        logic                      vo;
        logic [TAG_W-1:0]          ci;
        logic [TAG_W-1:0]          co;
        logic                      si;
        logic                      so;

        if (k == 1) begin : g_in
            assign a  = xin;
            assign vi = accept;
            assign ci = xin_chan;
            assign si = settle0;
        end else begin : g_link
            assign a  = g_stg[k-1].q;
            assign vi = g_stg[k-1].vo;
            assign ci = g_stg[k-1].co;
            assign si = g_stg[k-1].so;
        end

        diff_stage #(
            .IN_W    (WIDTH + k - 1),
            .CHANNELS(CHANNELS),
            .FIRST   (k == 1)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .clk_enable (clk_enable),
            .in_d       (a),
            .in_valid   (vi),
            .in_chan    (ci),
            .in_settled (si),
            .clr        (clr),
            .clr_chan   (clr_chan),
            .out_d      (q),
            .out_valid  (vo),
            .out_chan   (co),
            .out_settled(so)
        );
    end

    assign fin         = g_stg[ORDER].q;
    assign fin_valid   = g_stg[ORDER].vo;
    assign fin_chan    = g_stg[ORDER].co;
    assign fin_settled = g_stg[ORDER].so;

    always_ff @(posedge clk) begin
        if (reset) begin
            yout         <= '0;
            yout_valid   <= 1'b0;
            yout_chan    <= '0;
            yout_settled <= 1'b0;
            yout_ovf     <= 1'b0;
        end else if (clk_enable) begin
            yout_valid <= fin_valid;
            if (fin_valid) begin
                yout         <= OUT_W'(sat_val(MAX_W'(fin), OUT_W, SAT != 0));
                yout_ovf     <= sat_ovf(MAX_W'(fin), OUT_W);
                yout_chan    <= fin_chan;
                yout_settled <= fin_settled;
            end
        end
    end

endmodule

// File: tb/tb_diff_nth_mc.sv
// tb_diff_nth_mc: directed checks of diff_nth_mc (2-channel main
// instance plus 8-bit saturating and wrapping instances).
module tb_diff_nth_mc;

    typedef struct {
        logic signed [63:0] y;
        logic [3:0]         ch;
        logic               st;
        logic               ovf;
    } rec_t;

    logic clk = 1'b0;
    logic rst, en;
    logic en_q = 1'b0;

    logic signed [15:0] x;
    logic xv, xc, cl, clc;
    logic signed [18:0] a_y;
    logic a_v, a_c, a_st, a_ovf;

    logic signed [7:0] x8;
    logic v8, c8, cl8, clc8;
    logic signed [7:0] s_y, w_y;
    logic s_v, s_c, s_st, s_ovf;
    logic w_v, w_c, w_st, w_ovf;

    rec_t q_a[$], e_a[$], q_s[$], q_w[$];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    diff_nth_mc #(.ORDER(3), .CHANNELS(2), .WIDTH(16)) u_a (
        .clk(clk), .reset(rst), .clk_enable(en),
        .xin(x), .xin_valid(xv), .xin_chan(xc),
        .clr(cl), .clr_chan(clc),
        .yout(a_y), .yout_valid(a_v), .yout_chan(a_c),
        .yout_settled(a_st), .yout_ovf(a_ovf)
    );

    diff_nth_mc #(.ORDER(3), .CHANNELS(1), .WIDTH(8), .OUT_W(8), .SAT(1)) u_s (
        .clk(clk), .reset(rst), .clk_enable(en),
        .xin(x8), .xin_valid(v8), .xin_chan(c8),
        .clr(cl8), .clr_chan(clc8),
        .yout(s_y), .yout_valid(s_v), .yout_chan(s_c),
        .yout_settled(s_st), .yout_ovf(s_ovf)
    );

    diff_nth_mc #(.ORDER(3), .CHANNELS(1), .WIDTH(8), .OUT_W(8), .SAT(0)) u_w (
        .clk(clk), .reset(rst), .clk_enable(en),
        .xin(x8), .xin_valid(v8), .xin_chan(c8),
        .clr(cl8), .clr_chan(clc8),
        .yout(w_y), .yout_valid(w_v), .yout_chan(w_c),
        .yout_settled(w_st), .yout_ovf(w_ovf)
    );

    // Record one entry per output strobe on enabled edges only
    always @(posedge clk) en_q <= en;
    always @(negedge clk) begin
        if (en_q && a_v) q_a.push_back('{64'(a_y), 4'(a_c), a_st, a_ovf});
        if (en_q && s_v) q_s.push_back('{64'(s_y), 4'(s_c), s_st, s_ovf});
        if (en_q && w_v) q_w.push_back('{64'(w_y), 4'(w_c), w_st, w_ovf});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic ch, input int val,
                        input logic c, input logic cc);
        xv = v; xc = ch; x = 16'(val); cl = c; clc = cc;
        @(negedge clk);
    endtask

    task automatic tick8(input logic v, input logic ch, input int val);
        v8 = v; c8 = ch; x8 = 8'(val);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        xv = 0; cl = 0; v8 = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        idle(0);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        q_a.delete(); e_a.delete(); q_s.delete(); q_w.delete();
    endtask

    task automatic ex(input int y, input int ch, input bit st);
        e_a.push_back('{64'(y), 4'(ch), st, 1'b0});
    endtask

    task automatic cmp_a(input string tag);
        chk({tag, ".len"}, 64'(q_a.size()), 64'(e_a.size()));
        for (int i = 0; i < e_a.size(); i++) begin
            if (i < q_a.size()) begin
                chk($sformatf("%s[%0d].y", tag, i), q_a[i].y, e_a[i].y);
                chk($sformatf("%s[%0d].ch", tag, i), 64'(q_a[i].ch), 64'(e_a[i].ch));
                chk($sformatf("%s[%0d].st", tag, i), 64'(q_a[i].st), 64'(e_a[i].st));
                chk($sformatf("%s[%0d].ovf", tag, i), 64'(q_a[i].ovf), 64'(e_a[i].ovf));
            end
        end
        q_a.delete(); e_a.delete();
    endtask

    initial begin : main
        int e0[8], e1[8];
        int seq[9];
        int n0, n1;
        int sy[6], wy[6], ov[6];

        rst = 1; en = 1;
        x = 0; xv = 0; xc = 0; cl = 0; clc = 0;
        x8 = 0; v8 = 0; c8 = 0; cl8 = 0; clc8 = 0;
        do_reset;

        chk("rst.y", a_y, 0);
        chk("rst.v", 64'(a_v), 0);
        chk("rst.ch", 64'(a_c), 0);
        chk("rst.st", 64'(a_st), 0);
        chk("rst.ovf", 64'(a_ovf), 0);
        chk("rst.sy", s_y, 0);
        chk("rst.wv", 64'(w_v), 0);

        // impulse on ch0, latency 4 cycles
        tick(1, 0, 1, 0, 0); chk("lat.c1", 64'(a_v), 0);
        tick(1, 0, 0, 0, 0); chk("lat.c2", 64'(a_v), 0);
        tick(1, 0, 0, 0, 0); chk("lat.c3", 64'(a_v), 0);
        tick(1, 0, 0, 0, 0); chk("lat.c4", 64'(a_v), 1);
        chk("lat.y", a_y, 1);
        repeat (4) tick(1, 0, 0, 0, 0);
        idle(6);
        e0 = '{1, -3, 3, -1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ex(e0[i], 0, i >= 3);
        cmp_a("imp");

        do_reset;
        repeat (8) tick(1, 0, 5, 0, 0);
        idle(6);
        e0 = '{5, -10, 5, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ex(e0[i], 0, i >= 3);
        cmp_a("step");

        do_reset;
        for (int i = 0; i < 8; i++) tick(1, 0, i, 0, 0);
        idle(6);
        e0 = '{0, 1, -1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ex(e0[i], 0, i >= 3);
        cmp_a("ramp");

        do_reset;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, (i == 0) ? 1 : 0, 0, 0);
            tick(1, 1, 7, 0, 0);
        end
        idle(6);
        e0 = '{1, -3, 3, -1, 0, 0, 0, 0};
        e1 = '{7, -14, 7, 0, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            ex(e0[i], 0, i >= 3);
            ex(e1[i], 1, i >= 3);
        end
        cmp_a("ilv");

        do_reset;
        seq = '{0, 1, 1, 1, 0, 1, 0, 0, 0};
        n0 = 0; n1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (seq[i] == 0) begin
                tick(1, 0, (n0 == 0) ? 1 : 0, 0, 0);
                ex(e0[n0], 0, n0 >= 3); n0++;
            end else begin
                tick(1, 1, 7, 0, 0);
                ex(e1[n1], 1, n1 >= 3); n1++;
            end
        end
        idle(6);
        cmp_a("b2b");

        // clear ch1 coincident with a ch1 sample of 9
        do_reset;
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 2, 0, 0);
            tick(1, 1, (i < 4) ? 4 : 9, i == 4, 1);
        end
        idle(6);
        e0 = '{2, -4, 2, 0, 0, 0, 0, 0};
        e1 = '{4, -8, 4, 0, 9, -18, 9, 0};
        for (int i = 0; i < 8; i++) begin
            ex(e0[i], 0, i >= 3);
            ex(e1[i], 1, (i % 4) == 3);
        end
        cmp_a("clr");

        // reset with three samples in flight
        do_reset;
        tick(1, 1, 5, 0, 0);
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 2, 0, 0);
        tick(1, 0, 3, 0, 0);
        chk("pre.v", 64'(a_v), 1);
        chk("pre.y", a_y, 5);
        chk("pre.ch", 64'(a_c), 1);
        ex(5, 1, 0);
        idle(0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("inrst[%0d].v", i), 64'(a_v), 0);
            chk($sformatf("inrst[%0d].y", i), a_y, 0);
            chk($sformatf("inrst[%0d].ch", i), 64'(a_c), 0);
            @(negedge clk);
        end
        tick(1, 0, 4, 0, 0);
        idle(6);
        ex(4, 0, 0);
        cmp_a("rstfl");

        // stall for 5 cycles mid-stream; inputs during stall are ignored
        do_reset;
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        en = 0;
        repeat (5) tick(1, 0, 99, 1, 0);
        en = 1;
        repeat (4) tick(1, 0, 0, 0, 0);
        idle(6);
        e0 = '{1, -3, 3, -1, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) ex(e0[i], 0, i >= 3);
        cmp_a("stall");

        // 8-bit output: out-of-range tag dropped, then clamp / wrap
        do_reset;
        tick8(1, 1, 50);
        idle(6);
        chk("oor.len", 64'(q_s.size()), 0);
        for (int i = 0; i < 6; i++) tick8(1, 0, (i % 2) ? -128 : 127);
        idle(6);
        sy = '{127, -128, 127, -128, 127, -128};
        wy = '{127, 3, 124, 4, -4, 4};
        ov = '{0, 1, 1, 1, 1, 1};
        chk("sat.len", 64'(q_s.size()), 6);
        chk("wrap.len", 64'(q_w.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < q_s.size()) begin
                chk($sformatf("sat[%0d].y", i), q_s[i].y, 64'(sy[i]));
                chk($sformatf("sat[%0d].ovf", i), 64'(q_s[i].ovf), 64'(ov[i]));
                chk($sformatf("sat[%0d].st", i), 64'(q_s[i].st), 64'(i >= 3));
            end
            if (i < q_w.size()) begin
                chk($sformatf("wrap[%0d].y", i), q_w[i].y, 64'(wy[i]));
                chk($sformatf("wrap[%0d].ovf", i), 64'(q_w[i].ovf), 64'(ov[i]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
